avalon_burst_writer: RTL and testbench

- Parametrised successor to the FFT result uploader.
- After the FFT core signals completion, it reads NUM_SAMPLES words from the sample RAM, which has a synchronous read port.
- Each word is written to an Avalon-MM slave at an incrementing address, with full waitrequest and write-response handshaking.
- Error responses are retried a bounded number of times before the transfer aborts.

---
 rtl/avalon_burst_writer_if.sv | 35 +++
 rtl/avalon_burst_writer.sv | 134 +++++++++++++
 tb/tb_avalon_burst_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_burst_writer_if.sv
// Bus bundle for avalon_burst_writer: the sample RAM read port plus the
// Avalon-MM write master signals.
//   master modport : used by the writer (drives RAM address/enable and the
//                    Avalon request, receives RAM data, stall and response).
//   slave modport  : used by whatever models the RAM and the Avalon slave.
interface avalon_burst_writer_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 32,
    parameter int SAMP_AW = 9
);
    logic [SAMP_AW-1:0]  mem_addr;
    logic                mem_rd_en;
    logic [DATA_W-1:0]   mem_rdata;
    logic [ADDR_W-1:0]   av_address;
    logic                av_write;
    logic [DATA_W-1:0]   av_writedata;
    logic [DATA_W/8-1:0] av_byteenable;
    logic                av_waitrequest;
    logic                av_writeresponsevalid;
    logic [1:0]          av_response;

    modport master (
        output mem_addr, mem_rd_en,
        input  mem_rdata,
        output av_address, av_write, av_writedata, av_byteenable,
        input  av_waitrequest, av_writeresponsevalid, av_response
    );

    modport slave (
        input  mem_addr, mem_rd_en,
        output mem_rdata,
        input  av_address, av_write, av_writedata, av_byteenable,
        output av_waitrequest, av_writeresponsevalid, av_response
    );
endinterface

// File: rtl/avalon_burst_writer.sv
// avalon_burst_writer: after start, reads NUM_SAMPLES words from a sample RAM
// (synchronous read port) and writes each one to an Avalon-MM slave at an
// incrementing byte address, honouring waitrequest and the write response.
// Non-OKAY responses are retried up to MAX_RETRY times with the same data
// before the transfer aborts.
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   start       begin a transfer (only looked at in IDLE)
//   busy        high in every state except IDLE
//   done        one-cycle pulse on successful completion
//   error       sticky abort flag, cleared by reset or an accepted start
//   words_sent  words acknowledged OKAY in the current transfer
//   bus         RAM read port + Avalon write master (master modport)
module avalon_burst_writer #(
    parameter int              DATA_W      = 16,
    parameter int              ADDR_W      = 32,
    parameter int              SAMP_AW     = 9,
    parameter int              NUM_SAMPLES = 512,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [SAMP_AW:0]     words_sent,
    avalon_burst_writer_if.master bus
);

    localparam int               BYTES    = DATA_W / 8;
    localparam logic [SAMP_AW-1:0] LAST_IDX = SAMP_AW'(NUM_SAMPLES - 1);
    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WRITE, S_RESP, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [SAMP_AW-1:0]  idx_q, idx_d;
    logic [3:0]          retry_q, retry_d;
    logic [SAMP_AW:0]    ws_q, ws_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            ws_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            ws_q    <= ws_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        ws_d    = ws_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    retry_d = '0;
                    ws_d    = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                // RAM data is valid the cycle after the read enable.
                wdata_d = bus.mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!bus.av_waitrequest) state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.av_writeresponsevalid) begin
                    if (bus.av_response == 2'b00) begin
                        ws_d = ws_q + 1'b1;
                        // Terminal check before the increment keeps idx from wrapping.
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            retry_d = '0;
                            state_d = S_FETCH;
                        end
                    end else if (retry_q < MAX_R) begin
                        // Retry reuses wdata_q and idx; no RAM re-read.
                        retry_d = retry_q + 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign addr = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(BYTES);

    // Outputs decode the registered state, so the async reset clears them at once.
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign error             = err_q;
    assign words_sent        = ws_q;
    assign bus.mem_rd_en     = (state_q == S_FETCH);
    assign bus.mem_addr      = bus.mem_rd_en ? idx_q : '0;
    assign bus.av_write      = (state_q == S_WRITE);
    assign bus.av_address    = bus.av_write ? addr : '0;
    assign bus.av_writedata  = bus.av_write ? wdata_q : '0;
    assign bus.av_byteenable = {BYTES{bus.av_write}};

endmodule

// File: tb/tb_avalon_burst_writer.sv
module tb_avalon_burst_writer;
    localparam int DW   = 16;
    localparam int AW   = 32;
    localparam int SAW  = 4;
    localparam int NS   = 4;
    localparam logic [AW-1:0] BASE = 32'h1000;
    localparam int MR   = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            hold;
    } wr_t;

    logic clk, rst, start, busy, done, error;
    logic [SAW:0] words_sent;

    avalon_burst_writer_if #(.DATA_W(DW), .ADDR_W(AW), .SAMP_AW(SAW)) bus();

    avalon_burst_writer #(
        .DATA_W(DW), .ADDR_W(AW), .SAMP_AW(SAW), .NUM_SAMPLES(NS),
        .BASE_ADDR(BASE), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .error(error), .words_sent(words_sent), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Sample RAM model with synchronous read
    logic [DW-1:0] ram [0:(1<<SAW)-1];
    int rd_cnt = 0;
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rdata <= ram[bus.mem_addr];
            rd_cnt++;
        end
    end

    int done_total = 0;
    always @(negedge clk) if (done) done_total++;

    // Scoreboard and slave configuration
    wr_t          sb[$];
    logic [1:0]   resp_q[$];
    logic [AW-1:0] stall_addr;
    int           stall_n;
    bit           stall_armed = 0;
    bit           stray_req   = 0;

    bit           in_write, pend_resp, hold_ok;
    logic [1:0]   pend_code;
    int           stall_left, hold_cnt;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;

    // Avalon slave model: inputs change on the falling edge only
    always @(negedge clk) begin
        if (rst) begin
            in_write = 0; pend_resp = 0; stall_left = 0;
            sb.delete(); resp_q.delete();
            bus.av_waitrequest = 0; bus.av_writeresponsevalid = 0; bus.av_response = 2'b00;
        end else begin
            bus.av_writeresponsevalid = 0;
            bus.av_response = 2'b00;
            if (pend_resp) begin
                check_eq("resp_write_low", {63'd0, bus.av_write}, 64'd0);
                check_eq("resp_be_zero", {62'd0, bus.av_byteenable}, 64'd0);
                bus.av_writeresponsevalid = 1;
                bus.av_response = pend_code;
                pend_resp = 0;
            end else if (stray_req && bus.mem_rd_en) begin
                bus.av_writeresponsevalid = 1;
                bus.av_response = 2'b11;
                stray_req = 0;
            end
            bus.av_waitrequest = 0;
            if (bus.av_write) begin
                if (!in_write) begin
                    in_write = 1; hold_cnt = 0; hold_ok = 1;
                    hold_addr = bus.av_address; hold_data = bus.av_writedata;
                    if (stall_armed && bus.av_address == stall_addr) begin
                        stall_left = stall_n; stall_armed = 0;
                    end
                end
                hold_cnt++;
                if (bus.av_address != hold_addr || bus.av_writedata != hold_data
                    || bus.av_byteenable != 2'b11) hold_ok = 0;
                if (stall_left > 0) begin
                    bus.av_waitrequest = 1;
                    stall_left--;
                end else begin
                    in_write = 0;
                    check_eq("sb_has_entry", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        wr_t e;
                        e = sb.pop_front();
                        check_eq("wr_addr", 64'(hold_addr), 64'(e.addr));
                        check_eq("wr_data", 64'(hold_data), 64'(e.data));
                        check_eq("wr_hold_cycles", 64'(hold_cnt), 64'(e.hold));
                        check_eq("wr_stable", {63'd0, hold_ok}, 64'd1);
                    end
                    pend_code = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                    pend_resp = 1;
                end
            end
        end
    end

    task automatic push_wr(input int idx, input int hold);
        wr_t e;
        e.addr = BASE + AW'(idx * (DW / 8));
        e.data = ram[idx];
        e.hold = hold;
        sb.push_back(e);
    endtask

    task automatic push_plain;
        for (int i = 0; i < NS; i++) push_wr(i, 1);
    endtask

    task automatic run_xfer(input string tag, input bit spam, input int exp_cyc,
                            input int exp_done, input int exp_ws, input bit exp_err,
                            input int exp_rd);
        int cyc, dcnt, rd0;
        rd0 = rd_cnt; cyc = 0; dcnt = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = spam;
        check_eq({tag, "_err_clr"}, {63'd0, error}, 64'd0);
        for (int k = 0; k < 500; k++) begin
            if (!busy) break;
            cyc++;
            if (done) dcnt++;
            @(negedge clk); start = spam;
        end
        start = 0;
        check_eq({tag, "_idle_end"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        check_eq({tag, "_done_cnt"}, 64'(dcnt), 64'(exp_done));
        check_eq({tag, "_words_sent"}, 64'(words_sent), 64'(exp_ws));
        check_eq({tag, "_error"}, {63'd0, error}, 64'(exp_err));
        check_eq({tag, "_ram_reads"}, 64'(rd_cnt - rd0), 64'(exp_rd));
        check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_done"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_error"}, {63'd0, error}, 64'd0);
        check_eq({tag, "_words_sent"}, 64'(words_sent), 64'd0);
        check_eq({tag, "_rd_en"}, {63'd0, bus.mem_rd_en}, 64'd0);
        check_eq({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check_eq({tag, "_av_write"}, {63'd0, bus.av_write}, 64'd0);
        check_eq({tag, "_av_addr"}, 64'(bus.av_address), 64'd0);
        check_eq({tag, "_av_data"}, 64'(bus.av_writedata), 64'd0);
        check_eq({tag, "_av_be"}, 64'(bus.av_byteenable), 64'd0);
    endtask

    initial begin
        int dt0;
        bit found;
        rst = 1; start = 0;
        ram[0] = 16'h00A1; ram[1] = 16'h00B2; ram[2] = 16'h00C3; ram[3] = 16'h00D4;
        for (int i = NS; i < (1 << SAW); i++) ram[i] = 16'hEEEE;
        #12;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_all_zero("post_reset");

        // 1: plain transfer
        push_plain();
        run_xfer("t1", 0, 4*NS+1, 1, NS, 0, NS);

        // 2: 3-cycle stall on address 0x1002
        push_wr(0, 1); push_wr(1, 4); push_wr(2, 1); push_wr(3, 1);
        stall_addr = BASE + 2; stall_n = 3; stall_armed = 1;
        run_xfer("t2", 0, 4*NS+1+3, 1, NS, 0, NS);

        // 3: word 1 gets two SLVERR responses, then OKAY
        push_wr(0, 1); push_wr(1, 1); push_wr(1, 1); push_wr(1, 1); push_wr(2, 1); push_wr(3, 1);
        resp_q = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        run_xfer("t3", 0, 4*NS+1+4, 1, NS, 0, NS);

        // 4: word 0 fails four times -> abort, then a clean transfer
        for (int i = 0; i <= MR; i++) begin
            push_wr(0, 1);
            resp_q.push_back(2'b11);
        end
        run_xfer("t4", 0, 2 + 2*(MR+1) + 1, 0, 0, 1, 1);
        push_plain();
        run_xfer("t4b", 0, 4*NS+1, 1, NS, 0, NS);

        // 5: reset during the stall on word 3
        push_plain();
        stall_addr = BASE + 6; stall_n = 20; stall_armed = 1;
        dt0 = done_total;
        found = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (bus.av_write && bus.av_address == BASE + 6 && bus.av_waitrequest) begin
                found = 1;
                break;
            end
        end
        check_eq("t5_stall_reached", {63'd0, found}, 64'd1);
        #1 rst = 1;
        #1;
        check_all_zero("t5_async");
        @(negedge clk); @(negedge clk);
        rst = 0;
        stall_armed = 0;
        @(negedge clk); #1;
        check_eq("t5_no_done", 64'(done_total - dt0), 64'd0);
        check_all_zero("t5_after");
        push_plain();
        run_xfer("t5b", 0, 4*NS+1, 1, NS, 0, NS);

        // 6: start held every cycle plus a stray response in FETCH
        push_plain();
        stray_req = 1;
        dt0 = done_total;
        run_xfer("t6", 1, 4*NS+1, 1, NS, 0, NS);
        @(negedge clk); @(negedge clk);
        check_eq("t6_stray_used", {63'd0, stray_req}, 64'd0);
        check_eq("t6_one_done", 64'(done_total - dt0), 64'd1);
        check_eq("t6_idle_after", {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
